// File: rtl/sel_pipe_n.sv
// Registered N:1 selector with valid/ready handshake and a two-entry skid buffer.
// Out-of-range selects pass channel 0 and flag out_err alongside the beat.
module sel_pipe_n #(
   parameter int WIDTH  = 5,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t             state_r, state_s;
   logic [WIDTH-1:0] main_data_r, main_data_s;
   logic [WIDTH-1:0] skid_data_r, skid_data_s;
   logic             main_err_r, main_err_s;
   logic             skid_err_r, skid_err_s;
   logic             in_ready_r, in_ready_s;
   logic             out_valid_r;
   logic [WIDTH:0]   beat_s;
   logic             accept_s;
   logic             consume_s;

   // Returns {err, data}; unmatched select falls back to channel 0 with err set.
   function automatic logic [WIDTH:0] select_beat(input logic [NUM_IN*WIDTH-1:0] data,
                                                  input logic [SEL_W-1:0]        sel);
      logic [WIDTH:0] beat;
      beat = {1'b1, data[WIDTH-1:0]};
      for (int k = 0; k < NUM_IN; k++) begin
         beat = (sel == SEL_W'(k)) ? {1'b0, data[k*WIDTH +: WIDTH]} : beat;
      end
      return beat;
   endfunction

   assign beat_s    = select_beat(in_data, in_sel);
   assign accept_s  = in_valid && in_ready_r;
   assign consume_s = out_valid_r && out_ready;

   // Occupancy next-state and storage steering; flush overrides everything else.
   always_comb begin
      state_s     = state_r;
      main_data_s = main_data_r;
      main_err_s  = main_err_r;
      skid_data_s = skid_data_r;
      skid_err_s  = skid_err_r;
      if (flush) begin
         state_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  main_data_s = beat_s[WIDTH-1:0];
                  main_err_s  = beat_s[WIDTH];
                  state_s     = ONE;
               end else begin
                  state_s = EMPTY;
               end
            end
            ONE: begin
               if (accept_s && consume_s) begin
                  main_data_s = beat_s[WIDTH-1:0];
                  main_err_s  = beat_s[WIDTH];
                  state_s     = ONE;
               end else if (accept_s) begin
                  skid_data_s = beat_s[WIDTH-1:0];
                  skid_err_s  = beat_s[WIDTH];
                  state_s     = TWO;
               end else if (consume_s) begin
                  state_s = EMPTY;
               end else begin
                  state_s = ONE;
               end
            end
            TWO: begin
               // in_ready is low here, so no accept can race the skid drain
               if (consume_s) begin
                  main_data_s = skid_data_r;
                  main_err_s  = skid_err_r;
                  state_s     = ONE;
               end else begin
                  state_s = TWO;
               end
            end
            default: begin
               state_s = EMPTY;
            end
         endcase
      end
      in_ready_s = (state_s != TWO);
   end

   // State, storage and registered handshake outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= EMPTY;
         main_data_r <= {WIDTH{1'b0}};
         main_err_r  <= 1'b0;
         skid_data_r <= {WIDTH{1'b0}};
         skid_err_r  <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         main_data_r <= main_data_s;
         main_err_r  <= main_err_s;
         skid_data_r <= skid_data_s;
         skid_err_r  <= skid_err_s;
         in_ready_r  <= in_ready_s;
         out_valid_r <= (state_s != EMPTY);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_data  = main_data_r;
   assign out_err   = main_err_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sel_pipe_n.sv
// Scoreboard bench for sel_pipe_n: three instances (5b x4, 5b x3, 8b x16) share
// clock, reset and flush; expected beats are queued on accept and popped on consume.
module tb_sel_pipe_n;

   logic clk;
   logic rst_n;
   logic flush;

   logic [19:0]  a_data;
   logic [1:0]   a_sel;
   logic         a_iv, a_ir, a_oe, a_ov, a_or;
   logic [4:0]   a_od;
   logic [14:0]  b_data;
   logic [1:0]   b_sel;
   logic         b_iv, b_ir, b_oe, b_ov, b_or;
   logic [4:0]   b_od;
   logic [127:0] c_data;
   logic [3:0]   c_sel;
   logic         c_iv, c_ir, c_oe, c_ov, c_or;
   logic [7:0]   c_od;

   int checks = 0;
   int errors = 0;
   logic [8:0] q[3][$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sel_pipe_n #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(a_data), .in_sel(a_sel),
      .in_valid(a_iv), .in_ready(a_ir), .out_data(a_od), .out_err(a_oe),
      .out_valid(a_ov), .out_ready(a_or));

   sel_pipe_n #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(b_data), .in_sel(b_sel),
      .in_valid(b_iv), .in_ready(b_ir), .out_data(b_od), .out_err(b_oe),
      .out_valid(b_ov), .out_ready(b_or));

   sel_pipe_n #(.WIDTH(8), .NUM_IN(16), .SEL_W(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(c_data), .in_sel(c_sel),
      .in_valid(c_iv), .in_ready(c_ir), .out_data(c_od), .out_err(c_oe),
      .out_valid(c_ov), .out_ready(c_or));

   function automatic logic [8:0] model(logic [127:0] d, int sel, int n, int w);
      int          ch;
      logic [127:0] sh;
      logic [7:0]  mask;
      ch   = (sel < n) ? sel : 0;
      sh   = d >> (ch * w);
      mask = 8'((1 << w) - 1);
      return {(sel >= n), sh[7:0] & mask};
   endfunction

   task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pre(int i, logic iv, logic ir, logic ov, logic orr,
                      logic [8:0] obs, logic [8:0] exp_beat, string tag);
      logic [8:0] front;
      if (ov && orr) begin
         checks++;
         assert (q[i].size() > 0) else begin
            errors++;
            $error("FAIL %s_pop: observed beat %0h expected no beat", tag, obs);
         end
         if (q[i].size() > 0) begin
            front = q[i].pop_front();
            chk({tag, "_pop"}, obs, front);
         end
      end
      if (iv && ir) q[i].push_back(exp_beat);
   endtask

   task automatic post(int i, logic ir, logic ov, logic [8:0] obs, string tag);
      chk({tag, "_ready"}, {8'd0, ir}, {8'd0, (q[i].size() < 2)});
      chk({tag, "_valid"}, {8'd0, ov}, {8'd0, (q[i].size() > 0)});
      if (q[i].size() > 0) chk({tag, "_data"}, obs, q[i][0]);
   endtask

   task automatic step();
      bit drop;
      drop = flush || !rst_n;
      if (!drop) begin
         pre(0, a_iv, a_ir, a_ov, a_or, {a_oe, 3'd0, a_od},
             model({108'd0, a_data}, int'(a_sel), 4, 5), "a");
         pre(1, b_iv, b_ir, b_ov, b_or, {b_oe, 3'd0, b_od},
             model({113'd0, b_data}, int'(b_sel), 3, 5), "b");
         pre(2, c_iv, c_ir, c_ov, c_or, {c_oe, c_od},
             model(c_data, int'(c_sel), 16, 8), "c");
      end
      @(posedge clk);
      #1;
      if (drop) begin
         for (int i = 0; i < 3; i++) q[i].delete();
      end
      if (rst_n) begin
         post(0, a_ir, a_ov, {a_oe, 3'd0, a_od}, "a");
         post(1, b_ir, b_ov, {b_oe, 3'd0, b_od}, "b");
         post(2, c_ir, c_ov, {c_oe, c_od}, "c");
      end
   endtask

   initial begin
      int  k;
      bit  acc;
      rst_n  = 1'b0;
      flush  = 1'b0;
      a_data = 20'd0;  a_sel = 2'd0; a_iv = 1'b0; a_or = 1'b1;
      b_data = 15'd0;  b_sel = 2'd0; b_iv = 1'b0; b_or = 1'b1;
      c_data = 128'd0; c_sel = 4'd0; c_iv = 1'b0; c_or = 1'b1;

      // reset state
      step();
      step();
      chk("rst_valid", {8'd0, a_ov}, 9'd0);
      chk("rst_data",  {4'd0, a_od}, 9'd0);
      chk("rst_err",   {8'd0, a_oe}, 9'd0);
      chk("rst_ready", {8'd0, a_ir}, 9'd0);
      rst_n = 1'b1;
      step();
      chk("rst_ready_rise", {8'd0, a_ir}, 9'd1);

      // basic select: channel 2 of {31,7,19,3}
      a_data = {5'd31, 5'd7, 5'd19, 5'd3};
      a_sel  = 2'd2;
      a_iv   = 1'b1;
      step();
      a_iv = 1'b0;
      chk("basic_data",  {a_oe, 3'd0, a_od}, 9'h007);
      chk("basic_valid", {8'd0, a_ov}, 9'd1);
      step();
      chk("basic_one_cycle", {8'd0, a_ov}, 9'd0);

      // out-of-range select on the 3-channel instance
      b_data = {5'd9, 5'd22, 5'd12};
      b_sel  = 2'd3;
      b_iv   = 1'b1;
      step();
      b_sel = 2'd1;
      chk("oor_beat", {b_oe, 3'd0, b_od}, 9'h10C);
      step();
      b_iv = 1'b0;
      chk("inrange_beat", {b_oe, 3'd0, b_od}, 9'h016);
      step();

      // back-to-back stream with a two-cycle downstream stall
      a_data = {5'd4, 5'd3, 5'd2, 5'd1};
      k = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         a_or  = (cyc >= 2);
         a_iv  = (k < 4);
         a_sel = 2'(k);
         acc   = a_iv && a_ir;
         step();
         if (acc) k++;
         if (cyc == 1) begin
            chk("stall_ready_low", {8'd0, a_ir}, 9'd0);
            chk("stall_hold", {a_oe, 3'd0, a_od}, 9'h001);
         end
      end
      a_iv = 1'b0;
      chk("stall_all_accepted", 9'(k), 9'd4);
      chk("stall_drained", 9'(q[0].size()), 9'd0);

      // flush with main and skid full plus a concurrent input beat
      a_or  = 1'b0;
      a_iv  = 1'b1;
      a_sel = 2'd0;
      step();
      a_sel = 2'd1;
      step();
      chk("full_ready_low", {8'd0, a_ir}, 9'd0);
      flush = 1'b1;
      a_sel = 2'd2;
      step();
      flush = 1'b0;
      a_iv  = 1'b0;
      chk("flush_valid", {8'd0, a_ov}, 9'd0);
      chk("flush_ready", {8'd0, a_ir}, 9'd1);
      a_or = 1'b1;
      step();
      step();
      chk("flush_no_ghost", {8'd0, a_ov}, 9'd0);

      // reset with main and skid full
      a_or  = 1'b0;
      a_iv  = 1'b1;
      a_sel = 2'd0;
      step();
      a_sel = 2'd1;
      step();
      rst_n = 1'b0;
      a_iv  = 1'b0;
      step();
      chk("midrst_valid", {8'd0, a_ov}, 9'd0);
      chk("midrst_data",  {4'd0, a_od}, 9'd0);
      chk("midrst_err",   {8'd0, a_oe}, 9'd0);
      chk("midrst_ready", {8'd0, a_ir}, 9'd0);
      rst_n = 1'b1;
      step();
      chk("midrst_ready_rise", {8'd0, a_ir}, 9'd1);
      a_or  = 1'b1;
      a_iv  = 1'b1;
      a_sel = 2'd3;
      step();
      a_iv = 1'b0;
      chk("post_rst_beat", {a_oe, 3'd0, a_od}, 9'h004);
      step();

      // random soak on the 16-channel and 3-channel instances
      for (int cyc = 0; cyc < 600; cyc++) begin
         c_iv   = 1'($urandom_range(0, 1));
         c_or   = ($urandom_range(0, 3) != 0);
         c_sel  = 4'($urandom_range(0, 15));
         c_data = {$urandom, $urandom, $urandom, $urandom};
         b_iv   = 1'($urandom_range(0, 1));
         b_or   = 1'($urandom_range(0, 1));
         b_sel  = 2'($urandom_range(0, 3));
         b_data = 15'($urandom);
         step();
      end
      c_iv = 1'b0; c_or = 1'b1;
      b_iv = 1'b0; b_or = 1'b1;
      step();
      step();
      step();
      chk("soak_c_drained", 9'(q[2].size()), 9'd0);
      chk("soak_b_drained", 9'(q[1].size()), 9'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
